dpsram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that uses one dpsram instance as its storage array.
- Drives dpsram port 0 as write-only and port 1 as read-only.
- Consumes the 1-cycle-latency port-1 read data into a 2-entry output skid buffer, so the consumer sees a show-ahead valid/ready interface at full throughput.
- Used for deep instruction/refill queues in the frontend and LSU where register-based FIFOs are too large.

---
 rtl/dpsram_fifo_ctrl_pkg.sv | 19 +
 rtl/dpsram_fifo_ctrl_if.sv | 21 ++
 rtl/dpsram_fifo_ctrl_skid.sv | 63 ++++++
 rtl/dpsram_fifo_ctrl.sv | 97 +++++++++
 tb/tb_dpsram_fifo_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dpsram_fifo_ctrl_pkg.sv
// Shared definitions for SRAM-backed queues: pointer type and width derivations.
package dpsram_fifo_ctrl_pkg;

  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy spans 0..DEPTH+2 (SRAM plus in-flight read plus two skid entries).
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 3);
  endfunction

  localparam int unsigned FIFO_DEPTH_DEF  = 1024;
  localparam int unsigned FIFO_ADDR_W_DEF = fifo_addr_w(FIFO_DEPTH_DEF);

  // Pointer with one extra wrap bit above the SRAM address.
  typedef logic [FIFO_ADDR_W_DEF:0] fifo_ptr_t;

endpackage

// File: rtl/dpsram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle of the SRAM-backed FIFO.
interface dpsram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [DATA_WIDTH-1:0] push_data_i;
  logic                  pop_valid_o;
  logic                  pop_ready_i;
  logic [DATA_WIDTH-1:0] pop_data_o;

  modport slave (
    input  push_valid_i, push_data_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pop_data_o
  );

  modport master (
    output push_valid_i, push_data_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pop_data_o
  );
endinterface

// File: rtl/dpsram_fifo_ctrl_skid.sv
// Two-entry show-ahead output buffer absorbing the 1-cycle SRAM read latency.
module fifo_out_skid #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  cap_valid_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  output logic                  head_valid_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d;

  // Head pops and tail fills may coincide; entry 0 is always the head.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({pop_i, cap_valid_i})
      2'b11: begin
        if (cnt_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = cap_data_i;
        end else begin
          ent0_d = cap_data_i;
        end
      end
      2'b10: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd0) ent0_d = cap_data_i;
        else               ent1_d = cap_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      default: ;
    endcase
    if (flush_i) cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assert property (@(posedge clk) disable iff (rst) cnt_q <= 2'd2);

  assign head_valid_o = (cnt_q != 2'd0);
  assign head_data_o  = ent0_q;
  assign cnt_o        = cnt_q;

endmodule

// File: rtl/dpsram_fifo_ctrl.sv
// FIFO controller over an external dual-port SRAM: port 0 writes, port 1 reads into a skid buffer.
module dpsram_fifo_ctrl
  import dpsram_fifo_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 1024,
  localparam int unsigned ADDR_W     = fifo_addr_w(DEPTH),
  localparam int unsigned CNT_W      = fifo_cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  dpsram_fifo_ctrl_if.slave     bus,
  output logic [CNT_W-1:0]      count_o,
  output logic [ADDR_W-1:0]     sram_addr0_o,
  output logic                  sram_en0_o,
  output logic                  sram_we0_o,
  output logic [DATA_WIDTH-1:0] sram_wdata0_o,
  output logic [ADDR_W-1:0]     sram_addr1_o,
  output logic                  sram_en1_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata1_i
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_cnt;
  logic             rd_inflight_q, rd_inflight_d;
  logic             mem_full, mem_empty, push_fire, pop_fire, issue;
  logic [1:0]       ob_cnt;
  logic [2:0]       rd_pending;

  // Registered pointers only: an entry is never read in its write cycle.
  assign mem_cnt   = wr_ptr_q - rd_ptr_q;
  assign mem_full  = (mem_cnt == PTR_W'(DEPTH));
  assign mem_empty = (mem_cnt == '0);

  assign bus.push_ready_o = !rst && !flush_i && !mem_full;
  assign push_fire        = bus.push_valid_i && bus.push_ready_o;
  assign pop_fire         = bus.pop_valid_o && bus.pop_ready_i;

  // Issue a read only if its data will have a free skid slot on return.
  assign rd_pending = 3'(ob_cnt) + 3'(rd_inflight_q) - 3'(pop_fire);
  assign issue      = !rst && !mem_empty && !flush_i && (rd_pending < 3'd2);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_inflight_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (issue) begin
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
        rd_inflight_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  assign sram_addr0_o  = wr_ptr_q[ADDR_W-1:0];
  assign sram_en0_o    = push_fire;
  assign sram_we0_o    = push_fire;
  assign sram_wdata0_o = bus.push_data_i;
  assign sram_addr1_o  = rd_ptr_q[ADDR_W-1:0];
  assign sram_en1_o    = issue;

  // A read outstanding across a flush returns into a cleared skid and is dropped.
  fifo_out_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .cap_valid_i  (rd_inflight_q),
    .cap_data_i   (sram_rdata1_i),
    .pop_i        (pop_fire),
    .head_valid_o (bus.pop_valid_o),
    .head_data_o  (bus.pop_data_o),
    .cnt_o        (ob_cnt)
  );

  assign count_o = CNT_W'(mem_cnt) + CNT_W'(rd_inflight_q) + CNT_W'(ob_cnt);

endmodule

// File: tb/tb_dpsram_fifo_ctrl.sv
// Bench for dpsram_fifo_ctrl: SRAM model plus a queue-based reference FIFO.
module tb_dpsram_fifo_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned CW    = 11;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [CW-1:0] count;
  logic [AW-1:0] addr0, addr1;
  logic          en0, we0, en1;
  logic [DW-1:0] wdata0, rdata1;

  dpsram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  dpsram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .bus           (bus),
    .count_o       (count),
    .sram_addr0_o  (addr0),
    .sram_en0_o    (en0),
    .sram_we0_o    (we0),
    .sram_wdata0_o (wdata0),
    .sram_addr1_o  (addr1),
    .sram_en1_o    (en1),
    .sram_rdata1_i (rdata1)
  );

  // Dual-port SRAM with 1-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (en0 && we0) mem[addr0] <= wdata0;
    if (en1)        rdata1     <= mem[addr1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] q[$];
  int            wr_idx   = 0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;

  logic          s_pr, s_pv, s_en0, s_we0, s_en1, s_push_f, s_pop_f;
  logic [DW-1:0] s_pd;
  logic [CW-1:0] s_cnt;
  logic [AW-1:0] s_addr0, s_addr1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample and score before the rising edge.
  task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic pr,
                       input logic fl, input logic rs);
    @(negedge clk);
    rst              = rs;
    flush            = fl;
    bus.push_valid_i = pv;
    bus.push_data_i  = pd;
    bus.pop_ready_i  = pr;
    #1;
    s_pr = bus.push_ready_o; s_pv = bus.pop_valid_o; s_pd = bus.pop_data_o;
    s_en0 = en0; s_we0 = we0; s_en1 = en1; s_cnt = count;
    s_addr0 = addr0; s_addr1 = addr1;
    s_push_f = pv && s_pr;
    s_pop_f  = s_pv && pr;

    if (!rs) chk("count", 64'(s_cnt), 64'(q.size()));
    if (hold_pend) begin
      chk("hold_valid", 64'(s_pv), 64'd1);
      chk("hold_data", 64'(s_pd), 64'(hold_data));
    end
    if (rs)                           chk("rst_push_ready", 64'(s_pr), 64'd0);
    else if (fl)                      chk("flush_push_ready", 64'(s_pr), 64'd0);
    else if (q.size() < DEPTH)        chk("push_ready", 64'(s_pr), 64'd1);
    else if (q.size() == DEPTH + 2)   chk("full_push_ready", 64'(s_pr), 64'd0);
    if (!rs && q.size() == 0)         chk("empty_pop_valid", 64'(s_pv), 64'd0);
    chk("en0", 64'(s_en0), 64'(s_push_f));
    chk("we0", 64'(s_we0), 64'(s_push_f));
    if (s_push_f) chk("addr0", 64'(s_addr0), 64'(wr_idx % DEPTH));
    if (s_pop_f) begin
      if (q.size() == 0) chk("pop_spurious", 64'(s_pv), 64'd0);
      else               chk("pop_data", 64'(s_pd), 64'(q.pop_front()));
    end

    hold_pend = s_pv && !pr && !fl && !rs;
    hold_data = s_pd;
    if (s_push_f) begin
      q.push_back(pd);
      wr_idx++;
    end
    if (fl || rs) begin
      q.delete();
      wr_idx = 0;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (q.size() != 0 || s_pv); i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("drain_count", 64'(s_cnt), 64'd0);
    chk("drain_valid", 64'(s_pv), 64'd0);
  endtask

  initial begin
    int            accepted;
    logic [DW-1:0] seq;
    rst = 1'b1; flush = 1'b0;
    bus.push_valid_i = 1'b0; bus.push_data_i = '0; bus.pop_ready_i = 1'b0;

    // Reset
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_pop_valid", 64'(s_pv), 64'd0);
    chk("rst_count", 64'(s_cnt), 64'd0);
    chk("rst_en1", 64'(s_en1), 64'd0);
    chk("rst_push_ready_rel", 64'(s_pr), 64'd1);

    // Single push, latency
    cycle(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("lat_en1", 64'(s_en1), 64'd1);
    chk("lat_addr1", 64'(s_addr1), 64'd0);
    chk("lat_pv_e1", 64'(s_pv), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("lat_pv_e2", 64'(s_pv), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("lat_pv_e3", 64'(s_pv), 64'd1);
    chk("lat_data", 64'(s_pd), 64'hA5A5_0001);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lat_count_after", 64'(s_cnt), 64'd0);

    // Fill to capacity without popping
    accepted = 0;
    for (int i = 0; i < 1030; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      if (s_push_f) accepted++;
    end
    chk("fill_accepts", 64'(accepted), 64'(DEPTH + 2));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("fill_count", 64'(s_cnt), 64'(DEPTH + 2));
    chk("fill_ready", 64'(s_pr), 64'd0);
    drain();

    // Streaming: one push and one pop per cycle once primed
    seq = 32'h1000_0000;
    for (int i = 0; i < 5000; i++) begin
      cycle(1'b1, seq, 1'b1, 1'b0, 1'b0);
      seq++;
      if (i >= 3) chk("stream_gapless", 64'(s_pop_f), 64'd1);
    end
    drain();

    // Random traffic with 30% consumer backpressure
    for (int i = 0; i < 2500; i++)
      cycle($urandom_range(0, 99) < 70, DW'($urandom), $urandom_range(0, 99) >= 30, 1'b0, 1'b0);
    drain();

    // Flush with entries in SRAM and a read in flight
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(32'hF000 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_issue", 64'(s_en1), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pre_flush_count", 64'(s_cnt), 64'd5);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_count", 64'(s_cnt), 64'd0);
    chk("flush_pop_valid", 64'(s_pv), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_discard", 64'(s_pv), 64'd0);
    cycle(1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    drain();

    // Reset mid-stream
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 99) < 80, DW'($urandom), $urandom_range(0, 99) < 40, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    chk("midrst_en0", 64'(s_en0), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("midrst_count", 64'(s_cnt), 64'd0);
    chk("midrst_pop_valid", 64'(s_pv), 64'd0);
    chk("midrst_en1", 64'(s_en1), 64'd0);
    cycle(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    chk("midrst_addr0", 64'(s_addr0), 64'd0);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) >= 30, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
